// File: rtl/handshake_unpack_reg_if.sv
// Valid/ready bundle for the width down-converter.
// Wide side: input_valid/input_ready/input_payload/input_keep/input_last.
// Narrow side: output_valid/output_ready/output_payload/output_last.
// Modport master is the environment (producer + sink); slave is the converter.
interface handshake_unpack_reg_if #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
);
  localparam int unsigned IW = $clog2(N);

  logic              input_valid;
  logic              input_ready;
  logic [N*W-1:0]    input_payload;
  logic [IW-1:0]     input_keep;
  logic              input_last;
  logic              output_valid;
  logic              output_ready;
  logic [W-1:0]      output_payload;
  logic              output_last;

  modport master (
    output input_valid,
    output input_payload,
    output input_keep,
    output input_last,
    output output_ready,
    input  input_ready,
    input  output_valid,
    input  output_payload,
    input  output_last
  );

  modport slave (
    input  input_valid,
    input  input_payload,
    input  input_keep,
    input  input_last,
    input  output_ready,
    output input_ready,
    output output_valid,
    output output_payload,
    output output_last
  );
endinterface

// File: rtl/handshake_unpack_reg.sv
// Registered valid/ready width down-converter: takes one N*W-bit word per
// input handshake and emits up to N W-bit beats, least-significant first.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave modport of handshake_unpack_reg_if (wide in, narrow out)
// output_payload/output_last are decoded from registers only, so there is
// no combinational path from input_payload to output_payload.
module handshake_unpack_reg #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  handshake_unpack_reg_if.slave  bus
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned KW = IW + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [N*W-1:0]  word_q;
  logic [IW-1:0]   keep_q;
  logic [IW-1:0]   idx_q;
  logic            last_q;

  logic            output_valid;
  logic            final_beat;
  logic            input_ready;
  logic            in_fire;
  logic            out_fire;
  logic [W-1:0]    beat;
  logic            beat_last;
  logic [IW-1:0]   keep_clamped;

  // State register; BUSY is exactly "output_valid".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a final-beat handshake paired with a new word stays BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (out_fire && final_beat && !in_fire) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Output decode from registered state plus the downstream ready.
  always_comb begin
    output_valid = (state_q == BUSY);
    final_beat   = output_valid && (idx_q == keep_q);
    // Gated by rst_n so nothing is accepted while reset is asserted.
    input_ready  = rst_n && (!output_valid || (bus.output_ready && final_beat));
    in_fire      = bus.input_valid && input_ready;
    out_fire     = output_valid && bus.output_ready;
    beat_last    = last_q && final_beat;
    beat         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        beat = word_q[i*W +: W];
      end
    end
  end

  // Keep values beyond the last beat collapse to a full word.
  always_comb begin
    keep_clamped = bus.input_keep;
    if ({1'b0, bus.input_keep} > KW'(N - 1)) begin
      keep_clamped = IW'(N - 1);
    end
  end

  // Word/keep/last capture and beat index advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      idx_q  <= '0;
    end else if (in_fire) begin
      word_q <= bus.input_payload;
      keep_q <= keep_clamped;
      last_q <= bus.input_last;
      idx_q  <= '0;
    end else if (out_fire && !final_beat) begin
      idx_q  <= idx_q + IW'(1);
    end
  end

  assign bus.input_ready    = input_ready;
  assign bus.output_valid   = output_valid;
  assign bus.output_payload = beat;
  assign bus.output_last    = beat_last;

endmodule
